// File: rtl/byte_demux.sv
// byte_demux
//
// Routes one ready/valid byte stream to one of two output channels, each
// backed by a one-entry output register. The channel is chosen per byte by
// in_sel (0 -> channel 1, 1 -> channel 2). The channels drain independently,
// so a stalled channel never blocks bytes headed for the other channel.
// Each channel keeps a modulo-256 count of the bytes it has delivered.
//
// Channel register state (one copy per channel):
//   state | meaning
//   EMPTY | no byte held, outk_valid = 0
//   FULL  | byte held in outk_data, outk_valid = 1
//
// Ports
//   clk                     rising-edge clock
//   rst                     synchronous active-high reset
//   in_data[WIDTH-1:0]      input byte
//   in_sel                  channel select, sampled with in_data
//   in_valid / in_ready     input handshake
//   out1_data / out2_data   registered channel bytes
//   out1_valid / out2_valid channel holds a byte
//   out1_ready / out2_ready downstream accepts the channel byte
//   cnt1 / cnt2             bytes delivered per channel, modulo 256

module byte_demux #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [WIDTH-1:0] out2_data,
   output logic             out2_valid,
   input  logic             out2_ready,
   output logic [7:0]       cnt1,
   output logic [7:0]       cnt2
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } chan_state_t;

   chan_state_t state1, state1_next;
   chan_state_t state2, state2_next;

   logic can_accept1, can_accept2;
   logic load1, load2;
   logic xfer1, xfer2;

   always_comb begin
      // A FULL channel whose byte leaves this cycle can take a new byte in
      // the same cycle, so a streaming channel never bubbles.
      can_accept1 = (state1 == EMPTY) || out1_ready;
      can_accept2 = (state2 == EMPTY) || out2_ready;

      // Only the selected channel decides readiness; in_valid is kept out
      // of this path so upstream may wait for ready before raising valid.
      in_ready = in_sel ? can_accept2 : can_accept1;

      load1 = in_valid && in_ready && !in_sel;
      load2 = in_valid && in_ready &&  in_sel;

      out1_valid = (state1 == FULL);
      out2_valid = (state2 == FULL);

      xfer1 = out1_valid && out1_ready;
      xfer2 = out2_valid && out2_ready;

      state1_next = state1;
      case (state1)
         EMPTY: if (load1)           state1_next = FULL;
         FULL:  if (xfer1 && !load1) state1_next = EMPTY;
      endcase

      state2_next = state2;
      case (state2)
         EMPTY: if (load2)           state2_next = FULL;
         FULL:  if (xfer2 && !load2) state2_next = EMPTY;
      endcase
   end

   // Reset wins over any transfer in the same cycle, so a byte offered
   // while rst is high is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         state1    <= EMPTY;
         state2    <= EMPTY;
         out1_data <= '0;
         out2_data <= '0;
         cnt1      <= '0;
         cnt2      <= '0;
      end else begin
         state1 <= state1_next;
         state2 <= state2_next;
         if (load1) out1_data <= in_data;
         if (load2) out2_data <= in_data;
         if (xfer1) cnt1 <= cnt1 + 8'd1;
         if (xfer2) cnt2 <= cnt2 + 8'd1;
      end
   end

endmodule

// File: tb/tb_byte_demux.sv
// tb_byte_demux
//
// Directed bench for byte_demux. Inputs change on the falling edge; registered
// outputs are sampled 1 ns after the rising edge, and the combinational
// in_ready is sampled 1 ns after inputs change.

module tb_byte_demux;

   logic       clk;
   logic       rst;
   logic [7:0] in_data;
   logic       in_sel;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out1_data;
   logic       out1_valid;
   logic       out1_ready;
   logic [7:0] out2_data;
   logic       out2_valid;
   logic       out2_ready;
   logic [7:0] cnt1;
   logic [7:0] cnt2;

   int n_checks;
   int n_errors;
   int n_stall;

   byte_demux #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out1_data  (out1_data),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .out2_data  (out2_data),
      .out2_valid (out2_valid),
      .out2_ready (out2_ready),
      .cnt1       (cnt1),
      .cnt2       (cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // drive inputs just after the falling edge
   task automatic drive(input logic v, input logic s, input logic [7:0] d);
      @(negedge clk);
      in_valid = v;
      in_sel   = s;
      in_data  = d;
      #1;
   endtask

   // advance through the rising edge and settle
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      step();
      step();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      rst        = 1'b1;
      in_data    = 8'h00;
      in_sel     = 1'b0;
      in_valid   = 1'b0;
      out1_ready = 1'b1;
      out2_ready = 1'b1;

      // ---------------- reset state
      do_reset();
      #1;
      check("rst_v1",   out1_valid, 0);
      check("rst_v2",   out2_valid, 0);
      check("rst_d1",   out1_data,  0);
      check("rst_d2",   out2_data,  0);
      check("rst_c1",   cnt1,       0);
      check("rst_c2",   cnt2,       0);
      out1_ready = 1'b0;
      out2_ready = 1'b0;
      in_sel = 1'b0; #1;
      check("rst_rdy_s0", in_ready, 1);
      in_sel = 1'b1; #1;
      check("rst_rdy_s1", in_ready, 1);
      out1_ready = 1'b1;
      out2_ready = 1'b1;

      // ---------------- single byte on channel 1
      drive(1'b1, 1'b0, 8'hA5);
      check("a5_rdy", in_ready, 1);
      step();
      check("a5_v1", out1_valid, 1);
      check("a5_d1", out1_data,  8'hA5);
      check("a5_v2", out2_valid, 0);
      check("a5_c1_pre", cnt1, 0);
      drive(1'b0, 1'b1, 8'hFF);
      step();
      check("a5_v1_drained", out1_valid, 0);
      check("a5_c1", cnt1, 1);
      check("a5_c2", cnt2, 0);
      check("a5_v2_ign", out2_valid, 0);

      // ---------------- stalled channel 2 does not block channel 1
      out2_ready = 1'b0;
      drive(1'b1, 1'b1, 8'h3C);
      check("st_rdy_3c", in_ready, 1);
      step();
      check("st_v2", out2_valid, 1);
      check("st_d2", out2_data, 8'h3C);
      drive(1'b1, 1'b1, 8'h11);
      check("st_rdy_11", in_ready, 0);
      step();
      check("st_d2_hold", out2_data, 8'h3C);
      check("st_v2_hold", out2_valid, 1);
      check("st_v1_none", out1_valid, 0);
      drive(1'b0, 1'b1, 8'h11);
      check("st_rdy_novalid", in_ready, 0);
      drive(1'b1, 1'b0, 8'h22);
      check("st_rdy_22", in_ready, 1);
      step();
      check("st_v1_22", out1_valid, 1);
      check("st_d1_22", out1_data, 8'h22);
      check("st_d2_still", out2_data, 8'h3C);
      drive(1'b0, 1'b0, 8'h00);
      step();
      check("st_c1", cnt1, 2);
      check("st_c2_stalled", cnt2, 0);
      // release: a FULL channel with ready high can accept (pass-through)
      @(negedge clk);
      out2_ready = 1'b1;
      in_sel     = 1'b1;
      #1;
      check("st_rdy_pass", in_ready, 1);
      step();
      check("st_v2_drained", out2_valid, 0);
      check("st_c2", cnt2, 1);

      // ---------------- continuous alternating stream 0x00..0x0F
      do_reset();
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, i[0], i[7:0]);
         check($sformatf("str_rdy_%0d", i), in_ready, 1);
         step();
         if (i[0] == 1'b0) begin
            check($sformatf("str_v1_%0d", i), out1_valid, 1);
            check($sformatf("str_d1_%0d", i), out1_data, i);
            if (i > 0) check($sformatf("str_v2_%0d", i), out2_valid, 0);
         end else begin
            check($sformatf("str_v2_%0d", i), out2_valid, 1);
            check($sformatf("str_d2_%0d", i), out2_data, i);
            check($sformatf("str_v1_%0d", i), out1_valid, 0);
         end
      end
      drive(1'b0, 1'b0, 8'h00);
      step();
      check("str_c1", cnt1, 8);
      check("str_c2", cnt2, 8);
      check("str_v1_end", out1_valid, 0);
      check("str_v2_end", out2_valid, 0);

      // ---------------- 257 bytes on channel 1, counter wrap
      do_reset();
      n_stall = 0;
      for (int i = 0; i < 257; i++) begin
         drive(1'b1, 1'b0, i[7:0] ^ 8'h5A);
         if (in_ready !== 1'b1) n_stall++;
         step();
         if (i == 200) check("wrap_d1_200", out1_data, 8'hC8 ^ 8'h5A);
      end
      check("wrap_no_bubble", n_stall, 0);
      drive(1'b0, 1'b0, 8'h00);
      step();
      check("wrap_c1", cnt1, 1);
      check("wrap_c2", cnt2, 0);

      // ---------------- reset while both channels FULL and a byte offered
      out1_ready = 1'b0;
      out2_ready = 1'b0;
      drive(1'b1, 1'b0, 8'h55);
      step();
      drive(1'b1, 1'b1, 8'h66);
      step();
      check("mr_v1_full", out1_valid, 1);
      check("mr_v2_full", out2_valid, 1);
      @(negedge clk);
      rst        = 1'b1;
      out1_ready = 1'b1;
      out2_ready = 1'b1;
      in_valid   = 1'b1;
      in_sel     = 1'b0;
      in_data    = 8'h77;
      step();
      check("mr_v1", out1_valid, 0);
      check("mr_v2", out2_valid, 0);
      check("mr_c1", cnt1, 0);
      check("mr_c2", cnt2, 0);
      check("mr_d1", out1_data, 0);
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      #1;
      check("mr_rdy_s0", in_ready, 1);
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("mr_v1_after_%0d", i), out1_valid, 0);
         check($sformatf("mr_v2_after_%0d", i), out2_valid, 0);
      end
      check("mr_c1_after", cnt1, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
